// File: rtl/tribus_pkg.sv
// Shared state encoding, counter widths and sizing helpers for the tri-state bus arbiter.
package tribus_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    localparam int DEF_TURN_CYC = 1;
    localparam int DEF_MAX_HOLD = 16;
    localparam int TURN_W       = 4;
    localparam int HOLD_W       = 8;

    // Width of an owner index; never below one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tribus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker (rotate by ptr, fixed-priority encode, un-rotate).
module rr_pick
    import tribus_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] winner
);

    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;

    // rot[i] is req[(ptr + i) mod N], so bit 0 is the highest-priority requester.
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        valid = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid = 1'b1;
                off   = IDW'(i);
            end
        end
    end

    always_comb begin
        sum = {1'b0, off} + {1'b0, ptr};
        if (sum >= (IDW + 1)'(N)) begin
            winner = IDW'(sum - (IDW + 1)'(N));
        end else begin
            winner = sum[IDW-1:0];
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// tribus_arbiter: round-robin owner sequencer for a shared tri-state bus with all-off turnaround.
// Optional forced release after MAX_HOLD cycles is built when TRIBUS_TIMEOUT_EN is defined.
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int TURN_CYC = DEF_TURN_CYC,
    parameter  int MAX_HOLD = DEF_MAX_HOLD,
    localparam int IDW      = id_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   oe,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic [1:0]     dbg_state
);

    // Handshake: req is a level request held while ownership is wanted; grant answers it one
    // cycle later and stays until req drops (or preemption), followed by TURN_CYC all-off cycles.

    if (N < 2 || N > 16) begin : g_bad_n
        $error("tribus_arbiter: N must be 2..16");
    end
    if (TURN_CYC < 1 || TURN_CYC > 15) begin : g_bad_turn
        $error("tribus_arbiter: TURN_CYC must be 1..15");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("tribus_arbiter: MAX_HOLD must be 1..255");
    end

    state_t              state_q, state_n;
    logic [IDW-1:0]      ptr_q, ptr_n;
    logic [IDW-1:0]      gnt_id_q, gnt_id_n;
    logic [TURN_W-1:0]   turn_q, turn_n;
    logic [N-1:0]        grant_q, grant_n;
    logic                busy_q, busy_n;
    logic                pick_valid;
    logic [IDW-1:0]      pick_id;
    logic                preempt;

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_id)
    );

`ifdef TRIBUS_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_q, hold_n;

    // Only preempt when someone else is actually waiting.
    assign preempt = (hold_q == HOLD_LIM) && ((req & ~grant_q) != '0);
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_n  = state_q;
        ptr_n    = ptr_q;
        gnt_id_n = gnt_id_q;
        turn_n   = turn_q;
`ifdef TRIBUS_TIMEOUT_EN
        hold_n   = hold_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_n  = S_DRIVE;
                    gnt_id_n = pick_id;
`ifdef TRIBUS_TIMEOUT_EN
                    hold_n   = '0;
`endif
                end
            end
            S_DRIVE: begin
                if (!req[gnt_id_q] || preempt) begin
                    state_n  = S_TURN;
                    ptr_n    = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1;
                    turn_n   = TURN_W'(TURN_CYC - 1);
                    gnt_id_n = '0;
                end
`ifdef TRIBUS_TIMEOUT_EN
                else if (hold_q != HOLD_LIM) begin
                    hold_n = hold_q + 1'b1;
                end
`endif
            end
            S_TURN: begin
                if (turn_q != '0) begin
                    turn_n = turn_q - 1'b1;
                end else if (pick_valid) begin
                    state_n  = S_DRIVE;
                    gnt_id_n = pick_id;
`ifdef TRIBUS_TIMEOUT_EN
                    hold_n   = '0;
`endif
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        grant_n = (state_n == S_DRIVE) ? (N'(1) << gnt_id_n) : '0;
        busy_n  = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            gnt_id_q <= '0;
            turn_q   <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
`ifdef TRIBUS_TIMEOUT_EN
            hold_q   <= '0;
`endif
        end else begin
            state_q  <= state_n;
            ptr_q    <= ptr_n;
            gnt_id_q <= gnt_id_n;
            turn_q   <= turn_n;
            grant_q  <= grant_n;
            busy_q   <= busy_n;
`ifdef TRIBUS_TIMEOUT_EN
            hold_q   <= hold_n;
`endif
        end
    end

    // One register feeds both grant and oe so they can never disagree.
    assign grant     = grant_q;
    assign oe        = grant_q;
    assign gnt_id    = gnt_id_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Directed bench for tribus_arbiter: two instances (TURN_CYC=1 and TURN_CYC=3), N=4.
// Timeout expectations follow TRIBUS_TIMEOUT_EN the same way the design does.
module tb_tribus_arbiter;
    import tribus_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a = '0, req_b = '0;
    logic [3:0] grant_a, grant_b, oe_a, oe_b;
    logic [1:0] gnt_id_a, gnt_id_b, dbg_a, dbg_b;
    logic       busy_a, busy_b;

    int         total = 0;
    int         bad = 0;
    logic       mon_en = 1'b0;
    logic [1:0] exp_q[$];

    int         own_cnt[4];
    logic [3:0] drop;
    logic [3:0] prev_g;
    int         gap;
    logic       seen;
    logic [31:0] e;
    int         held_bad;

    tribus_arbiter #(.N(4), .TURN_CYC(1)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .grant(grant_a), .oe(oe_a),
        .gnt_id(gnt_id_a), .busy(busy_a), .dbg_state(dbg_a)
    );

    tribus_arbiter #(.N(4), .TURN_CYC(3)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .grant(grant_b), .oe(oe_b),
        .gnt_id(gnt_id_b), .busy(busy_b), .dbg_state(dbg_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_a = '0;
        req_b = '0;
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("oe_onehot_a", 32'($countones(oe_a) <= 1), 32'd1);
            check("oe_onehot_b", 32'($countones(oe_b) <= 1), 32'd1);
            check("oe_eq_grant_a", 32'(oe_a), 32'(grant_a));
        end
    end

    initial begin
        // reset state
        do_reset();
        mon_en = 1'b1;
        check("rst_grant", 32'(grant_a), 32'h0);
        check("rst_oe", 32'(oe_a), 32'h0);
        check("rst_gnt_id", 32'(gnt_id_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_state", 32'(dbg_a), 32'(S_IDLE));

        // single request, latency 1, release then turnaround then idle
        req_a = 4'b0100;
        tick();
        check("single_grant", 32'(grant_a), 32'h4);
        check("single_oe", 32'(oe_a), 32'h4);
        check("single_id", 32'(gnt_id_a), 32'd2);
        check("single_busy", 32'(busy_a), 32'd1);
        repeat (4) tick();
        check("single_hold", 32'(grant_a), 32'h4);
        req_a = 4'b0000;
        tick();
        check("single_turn_oe", 32'(oe_a), 32'h0);
        check("single_turn_busy", 32'(busy_a), 32'd1);
        check("single_turn_state", 32'(dbg_a), 32'(S_TURN));
        tick();
        check("single_idle_busy", 32'(busy_a), 32'd0);
        check("single_idle_state", 32'(dbg_a), 32'(S_IDLE));

        // all requesting: owners 0,1,2,3,0 with exactly one all-off cycle between
        do_reset();
        req_a = 4'b1111;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) own_cnt[i] = 0;
        drop   = '0;
        prev_g = '0;
        gap    = 0;
        seen   = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            tick();
            req_a = req_a | drop;
            drop  = '0;
            if (grant_a != '0 && prev_g == '0) begin
                e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hdead;
                check("rr_owner", 32'(gnt_id_a), e);
                check("rr_grant", 32'(grant_a), 32'd1 << e[4:0]);
                if (seen) check("rr_gap", 32'(gap), 32'd1);
                gap  = 0;
                seen = 1'b1;
            end else if (grant_a == '0) begin
                gap++;
                check("rr_turn_busy", 32'(busy_a), 32'd1);
            end
            prev_g = grant_a;
            for (int i = 0; i < 4; i++) begin
                if (grant_a[i]) begin
                    own_cnt[i]++;
                    if (own_cnt[i] == 3) begin
                        req_a[i]   = 1'b0;
                        drop[i]    = 1'b1;
                        own_cnt[i] = 0;
                    end
                end
            end
        end
        req_a = '0;
        check("rr_all_served", 32'(exp_q.size()), 32'd0);

        // TURN_CYC=3: owner 1 releases while req[3] waits
        do_reset();
        req_b = 4'b0010;
        tick();
        check("t3_owner1", 32'(grant_b), 32'h2);
        req_b = 4'b1010;
        repeat (2) tick();
        req_b = 4'b1000;
        for (int c = 4; c <= 6; c++) begin
            tick();
            check("t3_oe_off", 32'(oe_b), 32'h0);
            check("t3_busy", 32'(busy_b), 32'd1);
            check("t3_state", 32'(dbg_b), 32'(S_TURN));
        end
        tick();
        check("t3_grant3", 32'(grant_b), 32'h8);
        check("t3_id3", 32'(gnt_id_b), 32'd3);
        req_b = '0;

        // reset mid-DRIVE while ptr=2: pointer must return to 0
        do_reset();
        req_a = 4'b0010;
        tick();
        check("mid_owner1", 32'(grant_a), 32'h2);
        req_a = 4'b0000;
        tick();
        req_a = 4'b0100;
        tick();
        check("mid_owner2", 32'(grant_a), 32'h4);
        tick();
        rst   = 1'b1;
        req_a = 4'b0110;
        tick();
        check("mid_rst_grant", 32'(grant_a), 32'h0);
        check("mid_rst_oe", 32'(oe_a), 32'h0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_state", 32'(dbg_a), 32'(S_IDLE));
        rst = 1'b0;
        tick();
        check("mid_next_grant", 32'(grant_a), 32'h2);
        check("mid_next_id", 32'(gnt_id_a), 32'd1);

        // hold limit: req[0] held, req[2] joins at cycle 3
        do_reset();
        req_a    = 4'b0001;
        held_bad = 0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (c == 3) req_a = 4'b0101;
`ifdef TRIBUS_TIMEOUT_EN
            if (c == 16) check("to_last_hold", 32'(grant_a), 32'h1);
            if (c == 17) begin
                check("to_turn_oe", 32'(oe_a), 32'h0);
                check("to_turn_busy", 32'(busy_a), 32'd1);
            end
            if (c == 18) begin
                check("to_new_grant", 32'(grant_a), 32'h4);
                check("to_new_id", 32'(gnt_id_a), 32'd2);
            end
`else
            if (grant_a != 4'b0001) held_bad++;
`endif
        end
`ifdef TRIBUS_TIMEOUT_EN
        // no waiter, no preemption
        do_reset();
        req_a = 4'b0001;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (grant_a != 4'b0001) held_bad++;
        end
`endif
        check("hold_steady_cycles", 32'(held_bad), 32'd0);
        check("hold_final_grant", 32'(grant_a), 32'h1);
        req_a = '0;
        tick();

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
